// File: rtl/com_adc_capture_ctrl_if.sv
// Bundle of control, readout and sample-RAM port signals for the com ADC capture sequencer.
// slave is the sequencer's view; master is the view of whatever drives it and hosts the RAM.
interface com_adc_capture_ctrl_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned ADC_W  = 10,
    parameter int unsigned DATA_W = 16
);
    logic              arm;
    logic              abort;
    logic              force_trig;
    logic              adc_valid;
    logic [ADC_W-1:0]  adc_data;
    logic [ADC_W-1:0]  threshold;
    logic [ADDR_W-1:0] post_len;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] trig_addr;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_idx;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] mem_data;
    logic [ADDR_W-1:0] mem_wraddress;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_rdaddress;
    logic              mem_rden;
    logic [DATA_W-1:0] mem_q;

    modport master (
        output arm, abort, force_trig, adc_valid, adc_data, threshold, post_len,
        output rd_req, rd_idx, mem_q,
        input  busy, done, trig_addr, rd_valid, rd_data,
        input  mem_data, mem_wraddress, mem_wren, mem_rdaddress, mem_rden
    );

    modport slave (
        input  arm, abort, force_trig, adc_valid, adc_data, threshold, post_len,
        input  rd_req, rd_idx, mem_q,
        output busy, done, trig_addr, rd_valid, rd_data,
        output mem_data, mem_wraddress, mem_wren, mem_rdaddress, mem_rden
    );
endinterface

// File: rtl/com_adc_capture_ctrl.sv
// Circular-buffer capture of the com ADC stream into the 512x16 sample RAM with threshold or
// forced trigger, programmable post-trigger length, and oldest-relative pipelined readback.
module com_adc_capture_ctrl #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned ADC_W  = 10
) (
    input logic                   clock,
    input logic                   reset_n,
    com_adc_capture_ctrl_if.slave io_bus
);
    localparam int unsigned        DATA_W   = 16;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ARMED_WAIT,
        S_POST,
        S_DONE
    } state_e;

    state_e              r_state;
    state_e              w_state_nx;

    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADC_W-1:0]    r_prev;
    logic [ADDR_W-1:0]   r_post_len;
    logic [ADDR_W-1:0]   r_fill_cnt;
    logic [ADDR_W-1:0]   r_post_cnt;
    logic                r_force_pend;
    logic [ADDR_W-1:0]   r_trig_addr;
    logic                r_busy;
    logic                r_done;
    logic                r_mem_wren;
    logic [ADDR_W-1:0]   r_mem_wraddress;
    logic [DATA_W-1:0]   r_mem_data;
    logic                r_mem_rden;
    logic [ADDR_W-1:0]   r_mem_rdaddress;
    logic                r_rd_pend;
    logic                r_rd_valid;
    logic [DATA_W-1:0]   r_rd_data;

    logic                w_writing;
    logic                w_wr;
    logic                w_cross;
    logic                w_trig_hit;
    logic                w_arm_ok;
    logic                w_rd_ok;
    logic [ADDR_W-1:0]   w_pre_len;
    logic                w_fill_last;
    logic                w_post_last;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and per-cycle qualifiers; abort overrides everything
    always_comb begin
        w_state_nx  = r_state;
        w_writing   = (r_state == S_FILL) || (r_state == S_ARMED_WAIT) || (r_state == S_POST);
        w_wr        = w_writing && io_bus.adc_valid && !io_bus.abort;
        w_cross     = (r_prev < io_bus.threshold) && (io_bus.adc_data >= io_bus.threshold);
        w_trig_hit  = (r_state == S_ARMED_WAIT) && w_wr &&
                      (w_cross || io_bus.force_trig || r_force_pend);
        w_arm_ok    = io_bus.arm && !io_bus.abort && ((r_state == S_IDLE) || (r_state == S_DONE));
        w_rd_ok     = io_bus.rd_req && (r_state == S_DONE) && !io_bus.arm && !io_bus.abort;
        w_pre_len   = LAST_IDX - r_post_len;
        w_fill_last = w_wr && ((r_fill_cnt + ADDR_W'(1)) == w_pre_len);
        w_post_last = w_wr && ((r_post_cnt + ADDR_W'(1)) == r_post_len);

        if (io_bus.abort) begin
            w_state_nx = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_arm_ok) begin
                        w_state_nx = (io_bus.post_len == LAST_IDX) ? S_ARMED_WAIT : S_FILL;
                    end
                end
                S_FILL: begin
                    if (w_fill_last) w_state_nx = S_ARMED_WAIT;
                end
                S_ARMED_WAIT: begin
                    if (w_trig_hit) w_state_nx = (r_post_len == '0) ? S_DONE : S_POST;
                end
                S_POST: begin
                    if (w_post_last) w_state_nx = S_DONE;
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    // Write port, capture bookkeeping and the two-stage read pipeline
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr        <= '0;
            r_prev          <= '1;
            r_post_len      <= '0;
            r_fill_cnt      <= '0;
            r_post_cnt      <= '0;
            r_force_pend    <= 1'b0;
            r_trig_addr     <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_mem_wren      <= 1'b0;
            r_mem_wraddress <= '0;
            r_mem_data      <= '0;
            r_mem_rden      <= 1'b0;
            r_mem_rdaddress <= '0;
            r_rd_pend       <= 1'b0;
            r_rd_valid      <= 1'b0;
            r_rd_data       <= '0;
        end else begin
            r_busy     <= (w_state_nx == S_FILL) || (w_state_nx == S_ARMED_WAIT) ||
                          (w_state_nx == S_POST);
            r_done     <= (w_state_nx == S_DONE);
            r_mem_wren <= w_wr;

            if (w_wr) begin
                r_mem_wraddress <= r_wr_ptr;
                r_mem_data      <= {w_trig_hit, {(DATA_W-1-ADC_W){1'b0}}, io_bus.adc_data};
                r_wr_ptr        <= r_wr_ptr + ADDR_W'(1);
                r_prev          <= io_bus.adc_data;
            end
            if (w_wr && (r_state == S_FILL)) r_fill_cnt <= r_fill_cnt + ADDR_W'(1);
            if (w_wr && (r_state == S_POST)) r_post_cnt <= r_post_cnt + ADDR_W'(1);

            // A force without a sample is remembered so the next valid sample becomes the trigger
            if (w_trig_hit) begin
                r_trig_addr  <= r_wr_ptr;
                r_post_cnt   <= '0;
                r_force_pend <= 1'b0;
            end else if ((r_state == S_ARMED_WAIT) && io_bus.force_trig && !io_bus.abort) begin
                r_force_pend <= 1'b1;
            end

            if (w_arm_ok) begin
                r_post_len   <= io_bus.post_len;
                r_fill_cnt   <= '0;
                r_prev       <= '1;
                r_force_pend <= 1'b0;
            end
            if (io_bus.abort) r_force_pend <= 1'b0;

            r_mem_rden <= w_rd_ok;
            if (w_rd_ok) begin
                r_mem_rdaddress <= r_trig_addr + r_post_len + ADDR_W'(1) + io_bus.rd_idx;
            end
            r_rd_pend  <= r_mem_rden && !io_bus.abort;
            r_rd_valid <= r_rd_pend && !io_bus.abort;
            if (r_rd_pend && !io_bus.abort) r_rd_data <= io_bus.mem_q;
        end
    end

    assign io_bus.busy          = r_busy;
    assign io_bus.done          = r_done;
    assign io_bus.trig_addr     = r_trig_addr;
    assign io_bus.rd_valid      = r_rd_valid;
    assign io_bus.rd_data       = r_rd_data;
    assign io_bus.mem_data      = r_mem_data;
    assign io_bus.mem_wraddress = r_mem_wraddress;
    assign io_bus.mem_wren      = r_mem_wren;
    assign io_bus.mem_rdaddress = r_mem_rdaddress;
    assign io_bus.mem_rden      = r_mem_rden;

endmodule

// File: tb/tb_com_adc_capture_ctrl.sv
// Self-checking bench for com_adc_capture_ctrl: a sample-level capture model predicts every RAM
// write, the trigger address and the readback window; a behavioural RAM sits on the memory ports.
module tb_com_adc_capture_ctrl;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned ADC_W  = 10;
    localparam int K_RAMP = 0;
    localparam int K_FLAT = 1;
    localparam int K_RAND = 2;

    logic clock = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_ptr   = 0;
    int   trig_ptr;
    logic [15:0] win [512];
    logic [15:0] ram [512];

    com_adc_capture_ctrl_if #(.ADDR_W(ADDR_W), .ADC_W(ADC_W)) bus ();

    com_adc_capture_ctrl #(.ADDR_W(ADDR_W), .ADC_W(ADC_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .io_bus  (bus.slave)
    );

    always #5 clock = ~clock;

    // Behavioural sample RAM: registered read address, one-cycle read latency
    always @(posedge clock) begin
        if (bus.mem_wren) ram[bus.mem_wraddress] <= bus.mem_data;
        if (bus.mem_rden) bus.mem_q <= ram[bus.mem_rdaddress];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] snap();
        return {bus.busy, bus.done, bus.trig_addr, bus.rd_valid, bus.rd_data, bus.mem_wren,
                bus.mem_rden, bus.mem_wraddress, bus.mem_rdaddress, bus.mem_data};
    endfunction

    task automatic drive_idle();
        bus.arm = 1'b0; bus.abort = 1'b0; bus.force_trig = 1'b0; bus.adc_valid = 1'b0;
        bus.adc_data = '0; bus.threshold = '0; bus.post_len = '0; bus.rd_req = 1'b0; bus.rd_idx = '0;
    endtask

    // One capture: arm, stream samples until the model predicts done, optional abort/reset in POST
    task automatic capture(input int p, input logic [9:0] thr, input int kind, input logic [9:0] start,
                           input int force_after, input int glitch_at, input int stop_post,
                           input bit stop_is_reset);
        int pre, n, trig, armed_cyc, exp_addr;
        bit v, f, fin, stopped;
        logic [9:0] s, last_s, ramp, prev;
        logic pend, flag;
        logic [15:0] word;
        logic [15:0] w[$];
        pre = 511 - p; n = 0; trig = -1; armed_cyc = 0; pend = 1'b0; fin = 0; stopped = 0;
        ramp = start; last_s = '0; w.delete();
        bus.post_len = 9'(p); bus.threshold = thr; bus.arm = 1'b1;
        bus.rd_req = 1'b1; bus.rd_idx = 9'($urandom);
        @(posedge clock); #1;
        bus.arm = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL arm_start: busy=%b done=%b want busy=1 done=0", bus.busy, bus.done);
        end
        for (int cyc = 0; cyc < 6000 && !fin && !stopped; cyc++) begin
            v = ($urandom_range(0, 3) != 0);
            s = (kind == K_RAMP) ? ramp : (kind == K_FLAT) ? 10'h050 : 10'($urandom);
            f = 0;
            if (force_after > 0 && trig < 0 && n >= pre) begin
                armed_cyc++;
                if (armed_cyc == force_after) begin f = 1; v = 0; end
            end
            bus.arm      = (glitch_at > 0 && cyc == glitch_at);
            bus.post_len = bus.arm ? 9'(p + 37) : 9'(p);
            bus.rd_req   = ($urandom_range(0, 1) == 1);
            bus.rd_idx   = 9'($urandom);
            bus.abort    = (stop_post > 0 && !stop_is_reset && trig >= 0 && n == trig + 1 + stop_post);
            if (bus.abort) v = 1;
            bus.adc_valid = v; bus.adc_data = s; bus.force_trig = f;
            @(posedge clock); #1;
            if (bus.abort) begin
                bus.abort = 1'b0;
                n_tests++;
                if ({bus.busy, bus.done, bus.mem_wren} !== 3'b000) begin
                    n_fail++; $display("FAIL abort_state: busy/done/wren=%b want 000",
                                       {bus.busy, bus.done, bus.mem_wren});
                end
                for (int k = 0; k < 4; k++) begin
                    bus.adc_valid = 1'b1; bus.adc_data = 10'($urandom);
                    @(posedge clock); #1;
                    n_tests++;
                    if ({bus.busy, bus.mem_wren, bus.rd_valid} !== 3'b000) begin
                        n_fail++; $display("FAIL after_abort: busy/wren/rd_valid=%b want 000",
                                           {bus.busy, bus.mem_wren, bus.rd_valid});
                    end
                end
                stopped = 1;
            end else begin
                if (f && trig < 0 && n >= pre) pend = 1'b1;
                flag = 1'b0;
                exp_addr = m_ptr;
                word = '0;
                if (v) begin
                    prev = (n == 0) ? 10'h3FF : last_s;
                    if (trig < 0 && n >= pre && (pend || (prev < thr && s >= thr))) begin
                        trig = n; flag = 1'b1; trig_ptr = m_ptr; pend = 1'b0;
                    end
                    word = {flag, 5'b00000, s};
                    w.push_back(word);
                    m_ptr = (m_ptr + 1) % 512; n++; last_s = s;
                    if (kind == K_RAMP) ramp = ramp + 10'd1;
                end
                fin = (trig >= 0 && n == trig + 1 + p);
                n_tests++;
                if (bus.mem_wren !== v) begin
                    n_fail++; $display("FAIL wren cyc %0d: got %b want %b", cyc, bus.mem_wren, v);
                end
                if (v) begin
                    n_tests++;
                    if ({bus.mem_wraddress, bus.mem_data} !== {9'(exp_addr), word}) begin
                        n_fail++; $display("FAIL write cyc %0d: addr/data %h/%h want %h/%h", cyc,
                                           bus.mem_wraddress, bus.mem_data, 9'(exp_addr), word);
                    end
                end
                n_tests++;
                if ({bus.busy, bus.done} !== {~fin, fin}) begin
                    n_fail++; $display("FAIL status cyc %0d: busy/done %b%b want %b%b", cyc,
                                       bus.busy, bus.done, ~fin, fin);
                end
                n_tests++;
                if (bus.rd_valid !== 1'b0) begin
                    n_fail++; $display("FAIL rd_while_busy cyc %0d: rd_valid=%b want 0", cyc, bus.rd_valid);
                end
                if (stop_is_reset && stop_post > 0 && trig >= 0 && n == trig + 1 + stop_post && !fin) begin
                    #2 reset_n = 1'b0;
                    #1;
                    n_tests++;
                    if (snap() !== 64'd0) begin
                        n_fail++; $display("FAIL async_reset: outputs %h want 0", snap());
                    end
                    drive_idle();
                    @(posedge clock); #1;
                    reset_n = 1'b1;
                    m_ptr = 0;
                    stopped = 1;
                end
            end
        end
        bus.adc_valid = 1'b0; bus.rd_req = 1'b0; bus.force_trig = 1'b0; bus.arm = 1'b0; bus.abort = 1'b0;
        if (!stopped) begin
            n_tests++;
            if (!fin) begin
                n_fail++; $display("FAIL capture_timeout: done=%b want 1 after bounded cycles", bus.done);
            end else begin
                for (int i = 0; i < 512; i++) win[i] = w[w.size() - 512 + i];
                n_tests++;
                if (bus.trig_addr !== 9'(trig_ptr)) begin
                    n_fail++; $display("FAIL trig_addr: got %h want %h", bus.trig_addr, 9'(trig_ptr));
                end
            end
        end
    endtask

    task automatic read_one(input int idx, input logic [15:0] exp);
        bus.rd_req = 1'b1; bus.rd_idx = 9'(idx);
        @(posedge clock); #1;
        bus.rd_req = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        n_tests++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp) begin
            n_fail++; $display("FAIL read_idx_%0d: valid=%b data=%h want 1/%h", idx, bus.rd_valid,
                               bus.rd_data, exp);
        end
    endtask

    // Back-to-back requests; every response lands exactly two edges after its request
    task automatic read_burst(input int n, input bit fixed);
        int ids[16];
        bit exp_v;
        for (int i = 0; i < n; i++) ids[i] = fixed ? ((i == 3) ? 511 : i) : int'($urandom_range(0, 511));
        for (int c = 0; c < n + 3; c++) begin
            bus.rd_req = (c < n);
            bus.rd_idx = (c < n) ? 9'(ids[c]) : 9'd0;
            @(posedge clock); #1;
            exp_v = (c >= 2 && c - 2 < n);
            n_tests++;
            if (bus.rd_valid !== exp_v) begin
                n_fail++; $display("FAIL burst_valid c%0d: got %b want %b", c, bus.rd_valid, exp_v);
            end
            if (exp_v) begin
                n_tests++;
                if (bus.rd_data !== win[ids[c-2]]) begin
                    n_fail++; $display("FAIL burst_data idx %0d: got %h want %h", ids[c-2],
                                       bus.rd_data, win[ids[c-2]]);
                end
            end
        end
        bus.rd_req = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive_idle();
        repeat (3) @(posedge clock);
        #1;
        n_tests++;
        if (snap() !== 64'd0) begin
            n_fail++; $display("FAIL reset_values: outputs %h want 0", snap());
        end
        reset_n = 1'b1;
        m_ptr = 0;
        @(posedge clock); #1;
        n_tests++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_fail++; $display("FAIL idle_after_reset: busy/done %b%b want 00", bus.busy, bus.done);
        end
    endtask

    task automatic test_ignored_idle_reads();
        for (int c = 0; c < 6; c++) begin
            bus.rd_req = (c < 3); bus.rd_idx = 9'($urandom);
            @(posedge clock); #1;
            n_tests++;
            if ({bus.rd_valid, bus.mem_rden} !== 2'b00) begin
                n_fail++; $display("FAIL idle_read c%0d: rd_valid/rden %b%b want 00", c,
                                   bus.rd_valid, bus.mem_rden);
            end
        end
        bus.rd_req = 1'b0;
    endtask

    task automatic test_threshold_trigger();
        capture(100, 10'h200, K_RAMP, 10'h000, 0, 20, 0, 0);
        read_one(411, 16'h8200);
    endtask

    task automatic test_pipelined_reads();
        read_burst(4, 1'b1);
        read_burst(12, 1'b0);
    endtask

    task automatic test_force_trigger();
        capture(0, 10'h200, K_FLAT, 10'h000, 20, 0, 0, 0);
        read_one(511, 16'h8050);
        read_one(0, 16'h0050);
    endtask

    task automatic test_post_len_max();
        capture(511, 10'h200, K_RAMP, 10'h300, 0, 0, 0, 0);
        read_one(0, 16'h8200);
        read_burst(6, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 2; r++) begin
            capture(int'($urandom_range(0, 511)), 10'($urandom_range(10'h100, 10'h300)), K_RAND,
                    10'h000, 0, 0, 0, 0);
            read_burst(12, 1'b0);
        end
    endtask

    task automatic test_abort_post();
        capture(100, 10'h200, K_RAMP, 10'h000, 0, 0, 30, 0);
        capture(50, 10'h180, K_RAND, 10'h000, 0, 0, 0, 0);
        read_burst(8, 1'b0);
    endtask

    task automatic test_reset_post();
        capture(200, 10'h200, K_RAMP, 10'h000, 0, 0, 10, 1);
        capture(0, 10'h200, K_RAND, 10'h000, 0, 0, 0, 0);
        read_burst(6, 1'b0);
    endtask

    initial begin
        test_reset();
        test_ignored_idle_reads();
        test_threshold_trigger();
        test_pipelined_reads();
        test_force_trigger();
        test_post_len_max();
        test_random();
        test_abort_post();
        test_reset_post();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/com_adc_capture_ctrl.md
# com_adc_capture_ctrl

Sequences the 512 x 16 communications-ADC sample RAM (`com_adc_mem`) in the DOM FPGA. It records the com ADC stream into the RAM as a circular buffer, triggers on a threshold rising edge or a forced trigger, and keeps a programmable number of post-trigger samples. It then freezes the buffer and serves pipelined random-access reads, indexed from the oldest sample, to the local readout logic.

## Interface
- ADDR_W, 9, RAM address width (depth 2^ADDR_W = 512)
- ADC_W, 10, com ADC sample width
- clock  in  1  single clock; all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- arm  in  1  pulse; starts a capture from IDLE or DONE
- abort  in  1  pulse; returns to IDLE from any state
- force_trig  in  1  pulse; trigger now (ARMED_WAIT only)
- adc_valid  in  1  sample strobe
- adc_data  in  ADC_W  com ADC sample
- threshold  in  ADC_W  trigger level, unsigned
- post_len  in  ADDR_W  samples written after the trigger sample; latched at arm
- busy  out  1  high in FILL/ARMED_WAIT/POST
- done  out  1  high in DONE
- trig_addr  out  ADDR_W  RAM address of trigger sample
- rd_req  in  1  read request (honoured in DONE only)
- rd_idx  in  ADDR_W  sample index, 0 = oldest in window
- rd_valid  out  1  rd_data valid strobe
- rd_data  out  16  RAM word
- mem_data  out  16; mem_wraddress  out  ADDR_W; mem_wren  out  1 — RAM write port
- mem_rdaddress  out  ADDR_W; mem_rden  out  1; mem_q  in  16 — RAM read port

## Operation
- States: IDLE, FILL, ARMED_WAIT, POST, DONE. Reset -> IDLE.
- Word format: mem_data = {trig_flag, 5'b0, adc_data}. trig_flag = 1 only on the trigger sample.
- wr_ptr (ADDR_W) increments modulo 512 after each write. It is never cleared by arm.
- Writes occur only in FILL, ARMED_WAIT and POST, one per adc_valid.
- arm (IDLE/DONE):
  - latch post_len into P; pre_len = 511 - P
  - clear done and the fill counter
  - prev <= 10'h3FF
  - -> FILL, or -> ARMED_WAIT if pre_len = 0
- FILL: writes samples and sets prev <= adc_data on each. After pre_len writes -> ARMED_WAIT. Triggers are ignored in FILL.
- ARMED_WAIT: trigger when an adc_valid sample satisfies prev < threshold and adc_data >= threshold, or when force_trig is high.
  - force_trig without adc_valid: the next valid sample is the trigger sample.
  - The trigger sample is written with trig_flag = 1, and trig_addr <= its address.
  - -> DONE if P = 0, else -> POST.
- POST: writes P samples, then -> DONE.
- DONE: the buffer is frozen.
  - oldest = trig_addr + P + 1 (mod 512)
  - a read targets mem_rdaddress = oldest + rd_idx (mod 512)
- arm in FILL/ARMED_WAIT/POST is ignored.
- abort has priority over arm and triggers: -> IDLE, done = 0, and any in-flight write/read is dropped (rd_valid is not asserted).

## Timing
- Reset values: busy 0, done 0, trig_addr 0, rd_valid 0, rd_data 0, mem_wren 0, mem_rden 0, mem_wraddress 0, mem_rdaddress 0, mem_data 0. wr_ptr and prev are reset to 0 and 3FF respectively.
- Write: adc_valid is sampled at edge k. mem_wren, mem_wraddress and mem_data are registered at edge k and held high for one cycle.
- State change is coincident with the registering of the final write, so done rises on the edge that registers the last POST write.
- Read: rd_req is sampled at edge k, and mem_rden/mem_rdaddress are registered at edge k. The RAM captures the address at k+1, and rd_valid/rd_data are registered at edge k+2, for a fixed latency of 2.
- Reads are fully pipelined: one request per cycle is accepted, with no back-pressure.
- rd_req outside DONE is dropped.
- Simultaneous arm and rd_req in DONE: arm wins, and the read is dropped.

## Test plan
- Trigger with post_len=100, threshold=0x200:
  - stimulus: ramp adc 0x000..0x3FF repeating; arm.
  - response: busy; FILL writes 411 samples; trigger on the first crossing sample 0x200 (bit15 set); 100 more writes; done.
  - readback: rd_idx 411 returns 0x8200, and trig_addr = oldest + 411 mod 512.
- force_trig with a flat input:
  - stimulus: adc = 0x050, post_len=0.
  - response: no threshold trigger occurs; force_trig makes the next sample the trigger and done follows on that same write.
  - readback: rd_idx 511 = 0x8050.
- Edge case post_len=511:
  - response: FILL is skipped, and prev=3FF blocks a trigger on the first sample even if adc >= threshold.
  - response: a later rising crossing triggers, then 511 writes, then done.
  - readback: rd_idx 0 returns the trigger word.
- Pipelined reads:
  - stimulus: in DONE, rd_req on 4 consecutive cycles with rd_idx 0,1,2,511.
  - response: 4 consecutive rd_valid pulses, each 2 cycles after its request; addresses wrap modulo 512.
- Abort and reset mid-POST:
  - abort -> busy 0, done 0, no further mem_wren; a later arm works.
  - reset_n low asynchronously clears all outputs immediately.
- Ignored requests:
  - rd_req in IDLE/FILL produces no rd_valid.
  - arm while busy is ignored, and the capture completes normally.
